// File: rtl/postdelay_commutator.sv
// rtl/postdelay_commutator.sv - R2MDC receive-side commutator: path swap every DELAY samples, then upper-path delay
// Optional frame_done output is enabled by defining CM_FRAME_DONE_EN.
module postdelay_commutator #(
  parameter int DELAY = 16,
  parameter int DW    = 16
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          in_valid,
  input  logic [DW-1:0] in0_re,
  input  logic [DW-1:0] in0_im,
  input  logic [DW-1:0] in1_re,
  input  logic [DW-1:0] in1_im,
  output logic          out_valid,
  output logic [DW-1:0] out0_re,
  output logic [DW-1:0] out0_im,
  output logic [DW-1:0] out1_re,
  output logic [DW-1:0] out1_im
`ifdef CM_FRAME_DONE_EN
  ,
  output logic          frame_done
`endif
);

  localparam int KW = $clog2(2 * DELAY);
  localparam int PW = KW - 1;

  logic [KW-1:0]   k;
  logic [PW-1:0]   ptr;
  logic            primed;
  logic            sel;
  logic [2*DW-1:0] raw0;
  logic [2*DW-1:0] raw1;
  logic [2*DW-1:0] d0;
  logic [2*DW-1:0] ram [DELAY];

  assign sel = k[KW-1];
  assign ptr = k[PW-1:0];

  always_comb begin
    raw0 = {in0_re, in0_im};
    raw1 = {in1_re, in1_im};
    if (sel) begin
      raw0 = {in1_re, in1_im};
      raw1 = {in0_re, in0_im};
    end
  end

  // Combinational read plus non-blocking write gives read-before-write on the same slot.
  assign d0 = ram[ptr];

  always_ff @(posedge CLK) begin
    if (in_valid) begin
      ram[ptr] <= raw0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      k      <= '0;
      primed <= 1'b0;
    end else if (in_valid) begin
      k <= k + KW'(1);
      if (k == KW'(DELAY - 1)) begin
        primed <= 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      out_valid <= 1'b0;
      out0_re   <= '0;
      out0_im   <= '0;
      out1_re   <= '0;
      out1_im   <= '0;
    end else if (in_valid && primed) begin
      out_valid          <= 1'b1;
      {out0_re, out0_im} <= d0;
      {out1_re, out1_im} <= raw1;
    end else begin
      out_valid <= 1'b0;
    end
  end

`ifdef CM_FRAME_DONE_EN
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      frame_done <= 1'b0;
    end else begin
      frame_done <= in_valid && primed && (k == {KW{1'b1}});
    end
  end
`endif

endmodule

// File: tb/tb_postdelay_commutator.sv
// tb/tb_postdelay_commutator.sv - directed table-driven bench for postdelay_commutator (DELAY=4, DW=16)
// Checks frame_done as well when CM_FRAME_DONE_EN is defined.
module tb_postdelay_commutator;

  localparam int DELAY = 4;
  localparam int DW    = 16;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in0_re = '0;
  logic [DW-1:0] in0_im = '0;
  logic [DW-1:0] in1_re = '0;
  logic [DW-1:0] in1_im = '0;
  logic          out_valid;
  logic [DW-1:0] out0_re;
  logic [DW-1:0] out0_im;
  logic [DW-1:0] out1_re;
  logic [DW-1:0] out1_im;
`ifdef CM_FRAME_DONE_EN
  logic          frame_done;
`endif

  postdelay_commutator #(.DELAY(DELAY), .DW(DW)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .in_valid  (in_valid),
    .in0_re    (in0_re),
    .in0_im    (in0_im),
    .in1_re    (in1_re),
    .in1_im    (in1_im),
    .out_valid (out_valid),
    .out0_re   (out0_re),
    .out0_im   (out0_im),
    .out1_re   (out1_re),
    .out1_im   (out1_im)
`ifdef CM_FRAME_DONE_EN
    ,
    .frame_done(frame_done)
`endif
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int            n;
    logic [DW-1:0] e0;
    logic [DW-1:0] e1;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Present one sample (or a bubble) at the falling edge, sample results just after the rising edge.
  task automatic drive(input bit v, input int n);
    @(negedge CLK);
    in_valid = v;
    if (v) begin
      in0_re = DW'(n);
      in0_im = DW'(n + 1000);
      in1_re = DW'(100 + n);
      in1_im = DW'(1100 + n);
    end else begin
      in0_re = 16'hdead;
      in0_im = 16'hbeef;
      in1_re = 16'hcafe;
      in1_im = 16'hf00d;
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    in_valid = 1'b0;
    RST_N    = 1'b0;
    @(negedge CLK);
    RST_N    = 1'b1;
  endtask

  function automatic logic [DW-1:0] m_raw0(input int n);
    return ((n % (2 * DELAY)) >= DELAY) ? DW'(100 + n) : DW'(n);
  endfunction

  function automatic logic [DW-1:0] m_raw1(input int n);
    return ((n % (2 * DELAY)) >= DELAY) ? DW'(n) : DW'(100 + n);
  endfunction

  task automatic chk_pair(input string tag, input int n, input logic [DW-1:0] e0, input logic [DW-1:0] e1);
    chk($sformatf("%s out_valid n=%0d", tag, n), DW'(out_valid), DW'(1));
    chk($sformatf("%s out0_re n=%0d", tag, n), out0_re, e0);
    chk($sformatf("%s out1_re n=%0d", tag, n), out1_re, e1);
    chk($sformatf("%s out0_im n=%0d", tag, n), out0_im, e0 + DW'(1000));
    chk($sformatf("%s out1_im n=%0d", tag, n), out1_im, e1 + DW'(1000));
  endtask

  initial begin
    tbl[0]  = '{4, 0, 4};     tbl[1]  = '{5, 1, 5};
    tbl[2]  = '{6, 2, 6};     tbl[3]  = '{7, 3, 7};
    tbl[4]  = '{8, 104, 108}; tbl[5]  = '{9, 105, 109};
    tbl[6]  = '{10, 106, 110}; tbl[7]  = '{11, 107, 111};
    tbl[8]  = '{12, 8, 12};   tbl[9]  = '{13, 9, 13};
    tbl[10] = '{14, 10, 14};  tbl[11] = '{15, 11, 15};

    // Reset state
    #12;
    chk("rst out_valid", DW'(out_valid), DW'(0));
    chk("rst out0_re", out0_re, '0);
    chk("rst out0_im", out0_im, '0);
    chk("rst out1_re", out1_re, '0);
    chk("rst out1_im", out1_im, '0);
`ifdef CM_FRAME_DONE_EN
    chk("rst frame_done", DW'(frame_done), DW'(0));
`endif
    @(negedge CLK);
    RST_N = 1'b1;

    // Continuous stream: priming, then hand-computed pairs
    for (int n = 0; n < DELAY; n++) begin
      drive(1'b1, n);
      chk($sformatf("s1 prime out_valid n=%0d", n), DW'(out_valid), DW'(0));
    end
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, tbl[i].n);
      chk_pair("s1", tbl[i].n, tbl[i].e0, tbl[i].e1);
`ifdef CM_FRAME_DONE_EN
      chk($sformatf("s1 frame_done n=%0d", tbl[i].n), DW'(frame_done),
          DW'((tbl[i].n % 8) == 7));
`endif
    end

    // Bubbles after sample 6
    do_reset();
    for (int n = 0; n <= 6; n++) drive(1'b1, n);
    for (int b = 0; b < 3; b++) begin
      drive(1'b0, 0);
      chk($sformatf("s3 bubble out_valid b=%0d", b), DW'(out_valid), DW'(0));
      chk($sformatf("s3 bubble out0_re b=%0d", b), out0_re, DW'(2));
      chk($sformatf("s3 bubble out1_re b=%0d", b), out1_re, DW'(6));
`ifdef CM_FRAME_DONE_EN
      chk($sformatf("s3 bubble frame_done b=%0d", b), DW'(frame_done), DW'(0));
`endif
    end
    drive(1'b1, 7);
    chk_pair("s3", 7, DW'(3), DW'(7));

    // Long run across several wraps of the sample counter
    do_reset();
    for (int n = 0; n < 40; n++) begin
      drive(1'b1, n);
      if (n < DELAY) begin
        chk($sformatf("s4 prime out_valid n=%0d", n), DW'(out_valid), DW'(0));
      end else begin
        chk_pair("s4", n, m_raw0(n - DELAY), m_raw1(n));
      end
`ifdef CM_FRAME_DONE_EN
      chk($sformatf("s4 frame_done n=%0d", n), DW'(frame_done),
          DW'((n >= DELAY) && ((n % 8) == 7)));
`endif
    end

    // Asynchronous reset mid-stream, then re-priming from scratch
    do_reset();
    for (int n = 0; n <= 10; n++) drive(1'b1, n);
    chk("s5 pre-reset out_valid", DW'(out_valid), DW'(1));
    #2;
    RST_N    = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("s5 async out_valid", DW'(out_valid), DW'(0));
    chk("s5 async out0_re", out0_re, '0);
    chk("s5 async out1_re", out1_re, '0);
    chk("s5 async out0_im", out0_im, '0);
    chk("s5 async out1_im", out1_im, '0);
`ifdef CM_FRAME_DONE_EN
    chk("s5 async frame_done", DW'(frame_done), DW'(0));
`endif
    @(negedge CLK);
    RST_N = 1'b1;
    for (int n = 0; n < DELAY; n++) begin
      drive(1'b1, n);
      chk($sformatf("s5 reprime out_valid n=%0d", n), DW'(out_valid), DW'(0));
    end
    drive(1'b1, DELAY);
    chk_pair("s5", DELAY, DW'(0), DW'(4));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
